// File: rtl/reset_sequencer.sv
// reset_sequencer: merges reset requesters into one staged, active-high reset
// sequence. It holds all stages, waits for clock lock, then releases the stages
// one at a time in index order. It also records which sources caused the reset.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_ASSERT    | all stages held, hold counter running down
// ST_WAIT_LOCK | all stages held, waiting for lock_i, timeout counter running
// ST_RELEASE   | stages cleared one per gap period, lowest index first
// ST_RUN       | all stages released, sequence complete
module reset_sequencer #(
  parameter int NUM_SRC      = 4,
  parameter int NUM_STAGES   = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int GAP_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_n_i,
  input  logic [NUM_SRC-1:0]    req_i,
  input  logic                  lock_i,
  input  logic                  cause_clr_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  busy_o,
  output logic                  done_pulse_o,
  output logic [NUM_SRC:0]      cause_o,
  output logic [3:0]            retry_cnt_o
);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // One shared down-counter serves hold, lock-timeout and gap timing; only one
  // of them is ever live, and 16 bits covers the widest (lock timeout).
  localparam logic [15:0]         HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]         GAP_LOAD  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0]         TMO_LOAD  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [NUM_STAGES-1:0] STAGES_ALL = '1;
  localparam logic [NUM_SRC:0]    CAUSE_POR = {1'b1, {NUM_SRC{1'b0}}};

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic [NUM_SRC:0]        cause_q, cause_d;
  logic [3:0]              retry_q, retry_d;

  // Next-state logic: requests pre-empt everything, then the per-state sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    cause_d = cause_clr_i ? '0 : cause_q;
    retry_d = cause_clr_i ? 4'd0 : retry_q;

    if (|req_i) begin
      state_d                = ST_ASSERT;
      cnt_d                  = HOLD_LOAD;
      stage_d                = STAGES_ALL;
      cause_d[NUM_SRC-1:0]   = cause_d[NUM_SRC-1:0] | req_i;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          stage_d = STAGES_ALL;
          if (cnt_q == 16'd0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TMO_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          stage_d = STAGES_ALL;
          if (lock_i) begin
            // Stage bits clear lowest-first, so a left shift drops the next one.
            stage_d = STAGES_ALL << 1;
            cnt_d   = GAP_LOAD;
            if (stage_d == '0) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else if (cnt_q == 16'd0) begin
            state_d = ST_ASSERT;
            cnt_d   = HOLD_LOAD;
            if (retry_d != 4'd15) begin
              retry_d = retry_d + 4'd1;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == 16'd0) begin
            stage_d = stage_q << 1;
            cnt_d   = GAP_LOAD;
            if (stage_d == '0) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          stage_d = '0;
        end
      endcase
    end
  end

  // State and registered outputs; reset forces a fresh power-on sequence.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= HOLD_LOAD;
      stage_q <= STAGES_ALL;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
      retry_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      retry_q <= retry_d;
    end
  end

  assign stage_rst_o  = stage_q;
  assign busy_o       = |stage_q;
  assign done_pulse_o = done_q;
  assign cause_o      = cause_q;
  assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer. The reference model tracks event timestamps
// (when the hold started, when lock was accepted) and derives outputs from them.
module tb_reset_sequencer;

  localparam int NSRC = 4;
  localparam int NS   = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int TMO  = 1024;
  localparam int VW   = NS + 2 + NSRC + 1 + 4;

  logic              sys_clk_i = 1'b0;
  logic              sys_rst_n_i;
  logic [NSRC-1:0]   req_i;
  logic              lock_i;
  logic              cause_clr_i;
  logic [NS-1:0]     stage_rst_o;
  logic              busy_o;
  logic              done_pulse_o;
  logic [NSRC:0]     cause_o;
  logic [3:0]        retry_cnt_o;

  always #5 sys_clk_i = ~sys_clk_i;

  reset_sequencer #(
    .NUM_SRC(NSRC), .NUM_STAGES(NS), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .LOCK_TIMEOUT(TMO)
  ) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_n_i(sys_rst_n_i), .req_i(req_i),
    .lock_i(lock_i), .cause_clr_i(cause_clr_i), .stage_rst_o(stage_rst_o),
    .busy_o(busy_o), .done_pulse_o(done_pulse_o), .cause_o(cause_o),
    .retry_cnt_o(retry_cnt_o)
  );

  wire [VW-1:0] dut_vec = {stage_rst_o, busy_o, done_pulse_o, cause_o, retry_cnt_o};

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_edge;
  int            m_hold_start;
  int            m_lock_edge;
  logic [NSRC:0] m_cause;
  logic [3:0]    m_retry;

  function automatic logic [VW-1:0] exp_vec();
    logic [NS-1:0] st;
    logic          dn;
    for (int k = 0; k < NS; k++)
      st[k] = (m_lock_edge < 0) || (m_edge < m_lock_edge + k * GAP);
    dn = (m_lock_edge >= 0) && (m_edge == m_lock_edge + (NS - 1) * GAP);
    return {st, |st, dn, m_cause, m_retry};
  endfunction

  task automatic model_edge(input logic [NSRC-1:0] req, input logic lock, input logic clr);
    if (clr) begin
      m_cause = '0;
      m_retry = 4'd0;
    end
    if (|req) begin
      m_cause[NSRC-1:0] = m_cause[NSRC-1:0] | req;
      m_hold_start      = m_edge;
      m_lock_edge       = -1;
    end else if (m_lock_edge < 0 && m_edge > m_hold_start + HOLD) begin
      if (lock) begin
        m_lock_edge = m_edge;
      end else if (m_edge == m_hold_start + HOLD + TMO) begin
        m_hold_start = m_edge;
        if (m_retry != 4'd15) m_retry = m_retry + 4'd1;
      end
    end
  endtask

  task automatic step(input logic [NSRC-1:0] req, input logic lock, input logic clr);
    req_i       = req;
    lock_i      = lock;
    cause_clr_i = clr;
    @(posedge sys_clk_i);
    m_edge++;
    model_edge(req, lock, clr);
    #1;
  endtask

  task automatic reset_dut(input logic lock);
    sys_rst_n_i  = 1'b0;
    req_i        = '0;
    lock_i       = lock;
    cause_clr_i  = 1'b0;
    m_edge       = 0;
    m_hold_start = 0;
    m_lock_edge  = -1;
    m_cause      = {1'b1, {NSRC{1'b0}}};
    m_retry      = 4'd0;
    repeat (2) @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n_i = 1'b0;
    req_i = '0; lock_i = 1'b1; cause_clr_i = 1'b0;
    #12;
    checks++;
    if (dut_vec !== {3'b111, 1'b1, 1'b0, 5'b10000, 4'd0}) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec, {3'b111, 1'b1, 1'b0, 5'b10000, 4'd0});
    end
  endtask

  task automatic test_power_on();
    int          ms_edge[7] = '{16, 17, 24, 25, 32, 33, 34};
    logic [3:0]  ms_val[7]  = '{4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
    reset_dut(1'b1);
    for (int i = 0; i < 40; i++) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL power_on_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
      for (int j = 0; j < 7; j++) begin
        if (m_edge == ms_edge[j]) begin
          checks++;
          if ({stage_rst_o, done_pulse_o} !== ms_val[j]) begin
            errors++;
            $display("FAIL power_on_stage edge=%0d got=%b exp=%b", m_edge, {stage_rst_o, done_pulse_o}, ms_val[j]);
          end
        end
      end
    end
    checks++;
    if (cause_o !== 5'b10000) begin
      errors++;
      $display("FAIL power_on_cause got=%b exp=10000", cause_o);
    end
  endtask

  task automatic test_lock_timeout();
    int         ms_edge[6]  = '{1039, 1040, 2079, 2080, 15599, 15600};
    logic [3:0] ms_retry[6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd14, 4'd15};
    reset_dut(1'b0);
    while (m_edge < 17 * (HOLD + TMO)) begin
      step('0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
      for (int j = 0; j < 6; j++) begin
        if (m_edge == ms_edge[j]) begin
          checks++;
          if ({stage_rst_o, retry_cnt_o} !== {3'b111, ms_retry[j]}) begin
            errors++;
            $display("FAIL timeout_retry edge=%0d got=%h exp=%h", m_edge, {stage_rst_o, retry_cnt_o}, {3'b111, ms_retry[j]});
          end
        end
      end
    end
    checks++;
    if ({stage_rst_o, retry_cnt_o} !== {3'b111, 4'd15}) begin
      errors++;
      $display("FAIL timeout_saturate got=%h exp=%h", {stage_rst_o, retry_cnt_o}, {3'b111, 4'd15});
    end
  endtask

  task automatic test_request_in_run();
    int t;
    reset_dut(1'b1);
    while (m_edge < 40) step('0, 1'b1, 1'b0);
    t = m_edge + 1;
    step(4'b0100, 1'b1, 1'b0);
    checks++;
    if ({stage_rst_o, cause_o} !== {3'b111, 5'b10100}) begin
      errors++;
      $display("FAIL run_req_latency got=%h exp=%h", {stage_rst_o, cause_o}, {3'b111, 5'b10100});
    end
    while (m_edge < t + 45) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL run_req_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
      if (m_edge == t + 16 || m_edge == t + 17) begin
        checks++;
        if (stage_rst_o !== ((m_edge == t + 17) ? 3'b110 : 3'b111)) begin
          errors++;
          $display("FAIL run_req_restart edge=%0d got=%b", m_edge, stage_rst_o);
        end
      end
    end
    checks++;
    if (cause_o !== 5'b10100) begin
      errors++;
      $display("FAIL run_req_cause got=%b exp=10100", cause_o);
    end
  endtask

  task automatic test_request_during_release();
    int last;
    reset_dut(1'b0);
    while (m_edge < 1064) begin
      step('0, (m_edge >= 1040), 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL release_req_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
    end
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if ({stage_rst_o, cause_o, retry_cnt_o} !== {3'b111, 5'b10010, 4'd1}) begin
      errors++;
      $display("FAIL release_req_wins got=%h exp=%h", {stage_rst_o, cause_o, retry_cnt_o}, {3'b111, 5'b10010, 4'd1});
    end
    repeat (49) step(4'b0010, 1'b1, 1'b0);
    last = m_edge;
    while (m_edge < last + 20) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL held_req_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
      if (m_edge == last + 16 || m_edge == last + 17) begin
        checks++;
        if (stage_rst_o !== ((m_edge == last + 17) ? 3'b110 : 3'b111)) begin
          errors++;
          $display("FAIL held_req_release edge=%0d got=%b", m_edge, stage_rst_o);
        end
      end
    end
  endtask

  task automatic test_cause_clear();
    // Continues from the previous scenario: cause=10010, retry=1.
    step(4'b0001, 1'b1, 1'b1);
    checks++;
    if ({cause_o, retry_cnt_o} !== {5'b00001, 4'd0}) begin
      errors++;
      $display("FAIL clear_with_req got=%h exp=%h", {cause_o, retry_cnt_o}, {5'b00001, 4'd0});
    end
    reset_dut(1'b0);
    while (m_edge < 1039) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    checks++;
    if ({cause_o, retry_cnt_o} !== {5'b00000, 4'd1}) begin
      errors++;
      $display("FAIL clear_with_timeout got=%h exp=%h", {cause_o, retry_cnt_o}, {5'b00000, 4'd1});
    end
  endtask

  task automatic test_async_reset();
    reset_dut(1'b1);
    while (m_edge < 26) begin
      step('0, 1'b1, (m_edge == 4));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL async_pre_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
    end
    #2;
    sys_rst_n_i = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {3'b111, 1'b1, 1'b0, 5'b10000, 4'd0}) begin
      errors++;
      $display("FAIL async_reset_values got=%h exp=%h", dut_vec, {3'b111, 1'b1, 1'b0, 5'b10000, 4'd0});
    end
    reset_dut(1'b1);
    while (m_edge < 40) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL async_restart_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
      end
      if (m_edge == 17 || m_edge == 33) begin
        checks++;
        if (stage_rst_o !== ((m_edge == 17) ? 3'b110 : 3'b000)) begin
          errors++;
          $display("FAIL async_restart_stage edge=%0d got=%b", m_edge, stage_rst_o);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [NSRC-1:0] req;
    logic            lock;
    logic            clr;
    reset_dut(1'b1);
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 1300; i++) begin
        if (seg % 2 == 1) begin
          req  = ($urandom_range(0, 1999) == 0) ? 4'($urandom_range(1, 15)) : '0;
          lock = 1'b0;
        end else begin
          req  = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(1, 15)) : '0;
          lock = ($urandom_range(0, 9) != 0);
        end
        clr = ($urandom_range(0, 149) == 0);
        step(req, lock, clr);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL random_model edge=%0d got=%h exp=%h", m_edge, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge=%0d", m_edge);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_on();
    test_lock_timeout();
    test_request_in_run();
    test_request_during_release();
    test_cause_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
